// File: rtl/serializer_arbiter_if.sv
// Bundle of request-side and serializer-side signals for serializer_arbiter.
// slave  : the arbiter's view (requests and serializer status in, grants and launch out).
// master : the environment's view (requesters plus serializer), mirror of slave.
interface serializer_arbiter_if #(
  parameter int NREQ    = 4,
  parameter int ADDRW   = 8,
  parameter int OPCODEW = 2
) ();
  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]         req_valid;
  logic [NREQ*OPCODEW-1:0] req_opcode;
  logic [NREQ*ADDRW-1:0]   req_addr;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ-1:0]         done;
  logic                    done_err;
  logic                    ser_valid;
  logic [OPCODEW-1:0]      ser_opcode;
  logic [ADDRW-1:0]        ser_addr;
  logic                    ser_ready;
  logic                    ser_err;
  logic                    busy;
  logic [GW-1:0]           grant_id;

  modport slave (
    input  req_valid, req_opcode, req_addr, ser_ready, ser_err,
    output req_ready, done, done_err, ser_valid, ser_opcode, ser_addr, busy, grant_id
  );

  modport master (
    output req_valid, req_opcode, req_addr, ser_ready, ser_err,
    input  req_ready, done, done_err, ser_valid, ser_opcode, ser_addr, busy, grant_id
  );
endinterface

// File: rtl/serializer_arbiter.sv
// serializer_arbiter: shares one SPI response serializer between NREQ requesters.
// Round-robin grant in IDLE, launch into the serializer, track to completion,
// re-launch on serializer error up to MAX_RETRY times, then pulse done[owner].
// Optional feature: define SERARB_TIMEOUT_EN to abandon a launch that the
// serializer has not picked up within TIMEOUT_CYC cycles (reported as done_err).
module serializer_arbiter #(
  parameter int NREQ        = 4,
  parameter int ADDRW       = 8,
  parameter int OPCODEW     = 2,
  parameter int MAX_RETRY   = 3,
  parameter int TIMEOUT_CYC = 1023
) (
  input logic                 clk,
  input logic                 rst_n,
  serializer_arbiter_if.slave bus
);
  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

  if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYC < 1) begin : g_bad_params
    $error("serializer_arbiter: NREQ must be 2..8 and TIMEOUT_CYC >= 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_XFER   = 2'd2
  } state_e;

  state_e              state_q;
  logic [GW-1:0]       rr_q;
  logic [GW-1:0]       grant_q;
  logic [RW-1:0]       retry_q;
  logic [NREQ-1:0]     req_ready_q;
  logic [NREQ-1:0]     done_q;
  logic                done_err_q;
  logic                ser_valid_q;
  logic                busy_q;
  logic [OPCODEW-1:0]  opcode_q;
  logic [ADDRW-1:0]    addr_q;

  logic [GW-1:0]       pick_d;
  logic                any_req_d;
  logic [OPCODEW-1:0]  pick_op_d;
  logic [ADDRW-1:0]    pick_addr_d;

`ifdef SERARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0]       tmo_q;
`endif

  // Round-robin pick: first requesting index strictly after the last grant, wrapping.
  always_comb begin
    int          idx_v;
    logic [GW-1:0] sel_v;
    logic        hit_v;
    idx_v     = 0;
    sel_v     = '0;
    hit_v     = 1'b0;
    pick_d    = rr_q;
    any_req_d = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx_v     = int'(rr_q) + k;
      idx_v     = (idx_v >= NREQ) ? (idx_v - NREQ) : idx_v;
      sel_v     = GW'(idx_v);
      hit_v     = !any_req_d && bus.req_valid[sel_v];
      pick_d    = hit_v ? sel_v : pick_d;
      any_req_d = any_req_d | hit_v;
    end
    pick_op_d   = bus.req_opcode[int'(pick_d)*OPCODEW +: OPCODEW];
    pick_addr_d = bus.req_addr[int'(pick_d)*ADDRW +: ADDRW];
  end

  // Control FSM with all outputs registered; ser_err is only looked at on XFER completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rr_q        <= GW'(NREQ - 1);
      grant_q     <= '0;
      retry_q     <= '0;
      req_ready_q <= '0;
      done_q      <= '0;
      done_err_q  <= 1'b0;
      ser_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      opcode_q    <= '0;
      addr_q      <= '0;
`ifdef SERARB_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      req_ready_q <= '0;
      done_q      <= '0;
      done_err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (any_req_d) begin
            opcode_q    <= pick_op_d;
            addr_q      <= pick_addr_d;
            grant_q     <= pick_d;
            rr_q        <= pick_d;
            retry_q     <= '0;
            req_ready_q <= ONE_HOT0 << pick_d;
            ser_valid_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= ST_LAUNCH;
`ifdef SERARB_TIMEOUT_EN
            tmo_q       <= '0;
`endif
          end
        end
        ST_LAUNCH: begin
          // ready falling means the serializer has loaded the payload
          if (!bus.ser_ready) begin
            ser_valid_q <= 1'b0;
            state_q     <= ST_XFER;
          end
`ifdef SERARB_TIMEOUT_EN
          else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
            ser_valid_q <= 1'b0;
            done_q      <= ONE_HOT0 << grant_q;
            done_err_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end else begin
            tmo_q       <= tmo_q + TW'(1);
          end
`endif
        end
        ST_XFER: begin
          if (bus.ser_ready) begin
            if (bus.ser_err && (retry_q < RW'(MAX_RETRY))) begin
              retry_q     <= retry_q + RW'(1);
              ser_valid_q <= 1'b1;
              state_q     <= ST_LAUNCH;
`ifdef SERARB_TIMEOUT_EN
              tmo_q       <= '0;
`endif
            end else begin
              done_q      <= ONE_HOT0 << grant_q;
              done_err_q  <= bus.ser_err;
              busy_q      <= 1'b0;
              state_q     <= ST_IDLE;
            end
          end
        end
        default: begin
          ser_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.done       = done_q;
  assign bus.done_err   = done_err_q;
  assign bus.ser_valid  = ser_valid_q;
  assign bus.ser_opcode = opcode_q;
  assign bus.ser_addr   = addr_q;
  assign bus.busy       = busy_q;
  assign bus.grant_id   = grant_q;
endmodule
